// File: rtl/pkmc_bus_arbiter.sv
// pkmc_bus_arbiter
//   Arbitrates the shared board memory bus between the SRAM (0), SDRAM (1)
//   and FLASH (2) controllers. One owner at a time holds the bus in GRANT.
//   A TURN gap of TURN_CYCLES cycles follows every release so that no two
//   controllers ever drive the pins back to back.
//
// Parameters
//   TURN_CYCLES  idle cycles between a release and the next grant (1..15)
//   MAX_HOLD     GRANT cycles before the owner is asked to release while
//                others wait; 0 disables (0..255)
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req_i[2:0]              level requests {flash, sdram, sram}
//   sdram_refresh_urgent_i  gives req_i[1] top priority
//   gnt_o[2:0]              one-hot grant (registered)
//   mem_select_o[1:0]       board mux select; parks on the last owner
//   drive_allow_o           high only in GRANT
//   preempt_o               asks the owner to finish its burst and release
//   busy_o                  state is not IDLE
//   stat_grants_o[47:0]     {flash, sdram, sram} 16-bit grant counters
//   stat_wait_o[23:0]       saturating count of cycles with ungranted requests
//   The stat ports exist only when PKMC_ARB_STATS_EN is defined.

module pkmc_bus_arbiter #(
    parameter int unsigned TURN_CYCLES = 2,
    parameter int unsigned MAX_HOLD    = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req_i,
    input  logic        sdram_refresh_urgent_i,
    output logic [2:0]  gnt_o,
    output logic [1:0]  mem_select_o,
    output logic        drive_allow_o,
    output logic        preempt_o,
    output logic        busy_o
`ifdef PKMC_ARB_STATS_EN
    ,
    output logic [47:0] stat_grants_o,
    output logic [23:0] stat_wait_o
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURN
    } state_t;

    localparam logic [3:0] TURN_LAST  = 4'(TURN_CYCLES - 1);
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);
    localparam logic       HOLD_EN    = (MAX_HOLD != 0);

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  gnt_q;
    logic [1:0]  sel_q;
    logic [1:0]  rr_last_q;
    logic [7:0]  hold_q;
    logic [3:0]  turn_q;
    logic        preempt_q;
    logic        urgent_q;

    logic        has_req;
    logic        owner_req;
    logic        others_req;
    logic [1:0]  winner;
    logic        grant_start;
    logic        hold_hit;
    logic        urgent_pre;

    always_comb begin
        has_req    = |req_i;
        owner_req  = |(req_i & gnt_q);
        others_req = |(req_i & ~gnt_q);
        hold_hit   = HOLD_EN && (hold_q >= HOLD_LIMIT) && others_req;
        // Only a fresh rise of urgent, with SDRAM actually asking, while
        // somebody else owns the bus.
        urgent_pre = sdram_refresh_urgent_i && !urgent_q && req_i[1] && !gnt_q[1];
    end

    // Winner: urgent SDRAM first, else round-robin starting after rr_last.
    always_comb begin
        winner = 2'd0;
        if (sdram_refresh_urgent_i && req_i[1]) begin
            winner = 2'd1;
        end else begin
            case (rr_last_q)
                2'd0: begin
                    if (req_i[1])      winner = 2'd1;
                    else if (req_i[2]) winner = 2'd2;
                    else               winner = 2'd0;
                end
                2'd1: begin
                    if (req_i[2])      winner = 2'd2;
                    else if (req_i[0]) winner = 2'd0;
                    else               winner = 2'd1;
                end
                default: begin
                    if (req_i[0])      winner = 2'd0;
                    else if (req_i[1]) winner = 2'd1;
                    else               winner = 2'd2;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (has_req) state_d = GRANT;
            GRANT:   if (!owner_req) state_d = TURN;
            TURN: begin
                if (turn_q == '0) begin
                    state_d = has_req ? GRANT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant_start = (state_d == GRANT) && (state_q != GRANT);

    // Grant, select, hold, turnaround and preempt registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q     <= '0;
            sel_q     <= '0;
            rr_last_q <= 2'd2;
            hold_q    <= '0;
            turn_q    <= '0;
            preempt_q <= 1'b0;
            urgent_q  <= 1'b0;
        end else begin
            urgent_q <= sdram_refresh_urgent_i;
            if (grant_start) begin
                gnt_q     <= 3'b001 << winner;
                sel_q     <= winner;
                rr_last_q <= winner;
                hold_q    <= '0;
                preempt_q <= 1'b0;
            end else if (state_q == GRANT) begin
                if (!owner_req) begin
                    gnt_q     <= '0;
                    preempt_q <= 1'b0;
                    turn_q    <= TURN_LAST;
                end else begin
                    if (hold_q != '1) begin
                        hold_q <= hold_q + 8'd1;
                    end
                    // Sticky until release, even if the waiters go away.
                    if (hold_hit || urgent_pre) begin
                        preempt_q <= 1'b1;
                    end
                end
            end else if ((state_q == TURN) && (turn_q != '0)) begin
                turn_q <= turn_q - 4'd1;
            end
        end
    end

    // Outputs
    always_comb begin
        gnt_o         = gnt_q;
        mem_select_o  = sel_q;
        drive_allow_o = (state_q == GRANT);
        preempt_o     = preempt_q;
        busy_o        = (state_q != IDLE);
    end

`ifdef PKMC_ARB_STATS_EN
    logic [15:0] cnt_sram_q;
    logic [15:0] cnt_sdram_q;
    logic [15:0] cnt_flash_q;
    logic [23:0] wait_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_sram_q  <= '0;
            cnt_sdram_q <= '0;
            cnt_flash_q <= '0;
            wait_q      <= '0;
        end else begin
            if (grant_start) begin
                case (winner)
                    2'd0:    cnt_sram_q  <= cnt_sram_q + 16'd1;
                    2'd1:    cnt_sdram_q <= cnt_sdram_q + 16'd1;
                    default: cnt_flash_q <= cnt_flash_q + 16'd1;
                endcase
            end
            if ((|(req_i & ~gnt_q)) && (wait_q != '1)) begin
                wait_q <= wait_q + 24'd1;
            end
        end
    end

    always_comb begin
        stat_grants_o = {cnt_flash_q, cnt_sdram_q, cnt_sram_q};
        stat_wait_o   = wait_q;
    end
`endif

endmodule
